// File: rtl/injector_pkg.sv
// Shared definitions for the packet injector and its stream checker.
package injector_pkg;

  localparam int unsigned DEF_QUEUE_INDEX_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH        = 64;
  localparam int unsigned DEF_PKT_LEN_BYTES     = 64;
  localparam int unsigned DEF_CNT_WIDTH         = 32;

  // Payload field layout of every stream beat
  localparam int unsigned WORD_FIELD_LSB  = 0;
  localparam int unsigned WORD_FIELD_W    = 16;
  localparam int unsigned QUEUE_FIELD_LSB = 16;

  localparam int unsigned WORDS_PER_PKT = DEF_PKT_LEN_BYTES * 8 / DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_BODY   = 2'd2,
    ST_RESYNC = 2'd3
  } state_t;

  // Beats per packet for a given packet length and bus width
  function automatic int unsigned words_per_pkt(input int unsigned len_bytes,
                                                input int unsigned data_width);
    return len_bytes * 8 / data_width;
  endfunction

endpackage

// File: rtl/injector_stream_checker_if.sv
// Injector packet stream (AXI-Stream subset).
interface injector_stream_checker_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();
  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tready;

  modport master (output tdata, tvalid, tlast, tkeep, input tready);
  modport slave  (input tdata, tvalid, tlast, tkeep, output tready);
endinterface

// File: rtl/injector_count_ram.sv
// Per-queue counter storage: one write port, two registered read ports.
module injector_count_ram #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  a_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_data
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; reads on the same edge return the old contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port A feeds the increment pipeline
  always_ff @(posedge clk) begin
    if (a_en) a_data <= mem[a_addr];
  end

  // Read port B serves external count reads
  always_ff @(posedge clk) begin
    if (b_en) b_data <= mem[b_addr];
  end
endmodule

// File: rtl/injector_stream_checker.sv
// Checks injector packets (sequence, length, keep, queue round-robin) and
// keeps per-queue good-packet counts.
module injector_stream_checker
  import injector_pkg::*;
#(
  parameter int unsigned QUEUE_INDEX_WIDTH = DEF_QUEUE_INDEX_WIDTH,
  parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int unsigned PKT_LEN_BYTES     = DEF_PKT_LEN_BYTES,
  parameter int unsigned CNT_WIDTH         = DEF_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  injector_stream_checker_if.slave     s_axis_pkt,
  output logic                         init_done,
  input  logic                         rd_req_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] rd_req_idx,
  output logic                         rd_resp_valid,
  output logic [CNT_WIDTH-1:0]         rd_resp_count,
  output logic [63:0]                  total_pkts,
  output logic [CNT_WIDTH-1:0]         err_seq,
  output logic [CNT_WIDTH-1:0]         err_len,
  output logic [CNT_WIDTH-1:0]         err_keep,
  output logic [CNT_WIDTH-1:0]         err_rr
);
  localparam int unsigned QUEUE_COUNT = 2 ** QUEUE_INDEX_WIDTH;
  localparam int unsigned PKT_WORDS   = words_per_pkt(PKT_LEN_BYTES, DATA_WIDTH);
  localparam logic [WORD_FIELD_W-1:0] LAST_WORD = WORD_FIELD_W'(PKT_WORDS - 1);
  localparam logic [QUEUE_INDEX_WIDTH-1:0] LAST_QUEUE = QUEUE_INDEX_WIDTH'(QUEUE_COUNT - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t                         state;
  logic                           tready_q;
  logic [QUEUE_INDEX_WIDTH-1:0]   init_idx;
  logic [WORD_FIELD_W-1:0]        exp_word;
  logic [QUEUE_INDEX_WIDTH-1:0]   cur_q;
  logic                           pkt_bad;
  logic                           seq_ev, len_ev, keep_ev, good_ev;
  logic [QUEUE_INDEX_WIDTH-1:0]   good_q;
  logic                           rr_valid;
  logic [QUEUE_INDEX_WIDTH-1:0]   rr_prev;

  logic                           beat;
  logic                           keep_ok;
  logic                           word_mismatch;
  logic [WORD_FIELD_W-1:0]        word_f;
  logic [QUEUE_INDEX_WIDTH-1:0]   queue_f;
  logic                           unused_tdata;

  assign s_axis_pkt.tready = tready_q;
  assign beat          = s_axis_pkt.tvalid && tready_q;
  assign keep_ok       = &s_axis_pkt.tkeep;
  assign word_f        = s_axis_pkt.tdata[WORD_FIELD_LSB +: WORD_FIELD_W];
  assign queue_f       = s_axis_pkt.tdata[QUEUE_FIELD_LSB +: QUEUE_INDEX_WIDTH];
  assign word_mismatch = (word_f != exp_word) || (queue_f != cur_q);
  assign unused_tdata  = ^s_axis_pkt.tdata;

  // Packet FSM: RAM clear, header/body checking, resync; emits one-cycle events
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      tready_q  <= 1'b0;
      init_done <= 1'b0;
      init_idx  <= '0;
      exp_word  <= '0;
      cur_q     <= '0;
      pkt_bad   <= 1'b0;
      seq_ev    <= 1'b0;
      len_ev    <= 1'b0;
      keep_ev   <= 1'b0;
      good_ev   <= 1'b0;
      good_q    <= '0;
    end else begin
      seq_ev  <= 1'b0;
      len_ev  <= 1'b0;
      good_ev <= 1'b0;
      keep_ev <= beat && !keep_ok;
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + QUEUE_INDEX_WIDTH'(1);
          if (init_idx == LAST_QUEUE) begin
            state     <= ST_IDLE;
            tready_q  <= 1'b1;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (beat) begin
            if (word_f != '0) begin
              seq_ev <= 1'b1;
              state  <= s_axis_pkt.tlast ? ST_IDLE : ST_RESYNC;
            end else if (PKT_WORDS == 1) begin
              if (s_axis_pkt.tlast) begin
                good_ev <= keep_ok;
                good_q  <= queue_f;
              end else begin
                len_ev <= 1'b1;
                state  <= ST_RESYNC;
              end
            end else if (s_axis_pkt.tlast) begin
              len_ev <= 1'b1;
            end else begin
              cur_q    <= queue_f;
              exp_word <= WORD_FIELD_W'(1);
              pkt_bad  <= !keep_ok;
              state    <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (beat) begin
            seq_ev <= word_mismatch;
            if (exp_word == LAST_WORD) begin
              if (s_axis_pkt.tlast) begin
                good_ev <= !pkt_bad && !word_mismatch && keep_ok;
                good_q  <= cur_q;
                state   <= ST_IDLE;
              end else begin
                len_ev <= 1'b1;
                state  <= ST_RESYNC;
              end
            end else if (s_axis_pkt.tlast) begin
              len_ev <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              exp_word <= exp_word + WORD_FIELD_W'(1);
              pkt_bad  <= pkt_bad || word_mismatch || !keep_ok;
            end
          end
        end
        ST_RESYNC: begin
          if (beat && s_axis_pkt.tlast) state <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Saturating error/total counters and round-robin order check
  always_ff @(posedge clk) begin
    if (rst) begin
      total_pkts <= '0;
      err_seq    <= '0;
      err_len    <= '0;
      err_keep   <= '0;
      err_rr     <= '0;
      rr_valid   <= 1'b0;
      rr_prev    <= '0;
    end else begin
      if (seq_ev)  err_seq  <= sat_inc(err_seq);
      if (len_ev)  err_len  <= sat_inc(err_len);
      if (keep_ev) err_keep <= sat_inc(err_keep);
      if (good_ev) begin
        total_pkts <= (&total_pkts) ? total_pkts : total_pkts + 64'd1;
        if (rr_valid && (good_q != QUEUE_INDEX_WIDTH'(rr_prev + QUEUE_INDEX_WIDTH'(1))))
          err_rr <= sat_inc(err_rr);
        rr_prev  <= good_q;
        rr_valid <= 1'b1;
      end
    end
  end

  logic                         s2_v;
  logic [QUEUE_INDEX_WIDTH-1:0] s2_q;
  logic                         wb_v;
  logic [QUEUE_INDEX_WIDTH-1:0] wb_q;
  logic [CNT_WIDTH-1:0]         wb_data;
  logic [CNT_WIDTH-1:0]         ram_a_data;
  logic [CNT_WIDTH-1:0]         ram_b_data;
  logic [CNT_WIDTH-1:0]         cnt_base;
  logic [CNT_WIDTH-1:0]         cnt_next;
  logic                         ram_we;
  logic [QUEUE_INDEX_WIDTH-1:0] ram_waddr;
  logic [CNT_WIDTH-1:0]         ram_wdata;

  // Last cycle's write is not yet visible in the read data; forward it
  assign cnt_base = (wb_v && (wb_q == s2_q)) ? wb_data : ram_a_data;
  assign cnt_next = sat_inc(cnt_base);

  // Increment pipeline: read issued on good_ev, write one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_q    <= '0;
      wb_v    <= 1'b0;
      wb_q    <= '0;
      wb_data <= '0;
    end else begin
      s2_v    <= good_ev;
      s2_q    <= good_q;
      wb_v    <= s2_v;
      wb_q    <= s2_q;
      wb_data <= cnt_next;
    end
  end

  // Write port arbitration: clearing during INIT, increments otherwise
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s2_q;
    ram_wdata = cnt_next;
    if (state == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_idx;
      ram_wdata = '0;
    end else if (s2_v) begin
      ram_we = 1'b1;
    end
  end

  injector_count_ram #(
    .ADDR_WIDTH (QUEUE_INDEX_WIDTH),
    .DATA_WIDTH (CNT_WIDTH)
  ) u_count_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .a_en   (good_ev),
    .a_addr (good_q),
    .a_data (ram_a_data),
    .b_en   (rd_req_valid),
    .b_addr (rd_req_idx),
    .b_data (ram_b_data)
  );

  logic rq_v;
  logic rq_init;

  // Read response two cycles after request; requests made during INIT read 0
  always_ff @(posedge clk) begin
    if (rst) begin
      rq_v          <= 1'b0;
      rq_init       <= 1'b0;
      rd_resp_valid <= 1'b0;
      rd_resp_count <= '0;
    end else begin
      rq_v          <= rd_req_valid;
      rq_init       <= (state == ST_INIT);
      rd_resp_valid <= rq_v;
      rd_resp_count <= rq_init ? '0 : ram_b_data;
    end
  end
endmodule

// File: doc/injector_stream_checker.md
INJECTOR_STREAM_CHECKER -- requirements
Module: injector_stream_checker

Interface
REQ-001 QUEUE_INDEX_WIDTH, 4: queue ID width; QUEUE_COUNT = 2**QUEUE_INDEX_WIDTH.
REQ-002 DATA_WIDTH, 64: stream data width; shall be >= 16+QUEUE_INDEX_WIDTH.
REQ-003 PKT_LEN_BYTES, 64: packet length; WORDS_PER_PKT = PKT_LEN_BYTES*8/DATA_WIDTH, shall be >= 1.
REQ-004 CNT_WIDTH, 32: per-queue and error counter width.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 s_axis_pkt_tdata/tvalid/tlast/tkeep  in  DATA_WIDTH/1/1/DATA_WIDTH/8  injector stream.
REQ-009 s_axis_pkt_tready  out  1  stream ready.
REQ-010 init_done  out  1  counter RAM cleared.
REQ-011 rd_req_valid, rd_req_idx  in  1, QUEUE_INDEX_WIDTH  per-queue count read request.
REQ-012 rd_resp_valid, rd_resp_count  out  1, CNT_WIDTH  read response.
REQ-013 total_pkts  out  64  good packets.
REQ-014 err_seq, err_len, err_keep, err_rr  out  CNT_WIDTH each  error counters.

Function
REQ-015 Beat accepted when tvalid && tready; word field = tdata[15:0], queue field = tdata[16 +: QUEUE_INDEX_WIDTH].
REQ-016 tready = 1 in IDLE, BODY and RESYNC; 0 in INIT.
REQ-017 FSM states: INIT, IDLE, BODY, RESYNC.
REQ-018 INIT: clears one RAM entry per cycle, entries 0..QUEUE_COUNT-1; after last entry -> IDLE, init_done = 1 from next cycle until reset.
REQ-019 IDLE: on beat, word field != 0 -> err_seq++, then RESYNC if !tlast, else stay IDLE; otherwise latch queue, expected word = 1, go BODY (or complete packet if WORDS_PER_PKT == 1 and tlast).
REQ-020 BODY: word field != expected or queue field != latched queue -> err_seq++, packet marked bad.
REQ-021 tlast before word WORDS_PER_PKT-1 -> err_len++, -> IDLE, no count update.
REQ-022 No tlast on word WORDS_PER_PKT-1 -> err_len++, -> RESYNC.
REQ-023 RESYNC: discard beats; on tlast -> IDLE.
REQ-024 Any beat with tkeep != all-ones -> err_keep++, packet marked bad.
REQ-025 Packet good when tlast on word WORDS_PER_PKT-1 with no flags; total_pkts++ and queue count incremented.
REQ-026 Count update is 2-stage read-modify-write; back-to-back updates to same queue shall forward the in-flight value (no lost increments).
REQ-027 All counters saturate at max; no wrap.
REQ-028 Round-robin check: each good packet after the first since reset, queue != (previous good queue + 1) mod QUEUE_COUNT -> err_rr++.
REQ-029 Readout: rd_req_valid at cycle N -> rd_resp_valid = 1 and rd_resp_count at N+2, one cycle wide; independent read port; same-cycle update to same queue may return old or new value.
REQ-030 rd_req_valid during INIT: response returns 0.
REQ-031 Several error events on one beat each increment their own counter once.

Reset
REQ-032 rst -> state INIT, init_done 0, tready 0, rd_resp_valid 0, all counters 0, RR history cleared, in-flight RMW discarded.
REQ-033 rst mid-packet or mid-INIT restarts INIT from entry 0.

Structure
REQ-034 Shared package injector_pkg: state enum, WORDS_PER_PKT, word/queue field offsets, shared with massive_traffic_injector.
REQ-035 One sub-module: injector_count_ram (QUEUE_COUNT x CNT_WIDTH, one write, two registered read ports).

Verification
REQ-036 Defaults; reset; 16-cycle INIT; 32 packets in queues 0..15 twice -> total_pkts 32, every queue count 2, all errors 0.
REQ-037 Queue 5 back-to-back three times -> queue 5 count 3 (forwarding), err_rr 2.
REQ-038 tlast on word 3 -> err_len 1, no count change; next good packet counted.
REQ-039 Word field 2 sent where 1 expected -> err_seq 1, packet not counted.
REQ-040 tkeep 0x0F on one beat -> err_keep 1; random tvalid gaps over 100 packets -> no errors.
REQ-041 rst asserted mid-packet -> all outputs at reset values, INIT reruns, clean traffic counted from zero.
